mem_ctrl: RTL and testbench

Memory access sequencer between the CPU control unit and external memory. It accepts single read or write requests from control and drives the `mem_rd`/`mem_wr` strobes using a ready handshake. For reads it loads the MDR with returned data. It stalls control with `busy` until the access completes and reports illegal requests and timeouts on `err`.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/mem_wait_timer.sv | 25 ++
 rtl/mem_ctrl.sv | 105 ++++++++++
 tb/tb_mem_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the memory access sequencer: FSM states and the captured operation.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } mem_state_e;

  typedef enum logic {
    MEM_OP_RD = 1'b0,
    MEM_OP_WR = 1'b1
  } mem_op_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Clear/enable wait counter that saturates at WAIT_MAX-1; o_expired flags the last allowed cycle.
module mem_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_cnt <= '0;
    else if (i_clr)              r_cnt <= '0;
    else if (i_en && r_cnt != LAST) r_cnt <= r_cnt + CW'(1);
  end

  assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/mem_ctrl.sv
// Memory access sequencer: one read or write per request, ready handshake, MDR load on read.
// Define MEM_CTRL_TIMEOUT_EN to compile in the WAIT_MAX wait timer and timeout abort.
module mem_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [31:0] mar_value,
  input  logic [31:0] mdr_value,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        ld_mdr,
  output logic [31:0] mdr_in,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  if (WAIT_MAX < 1) begin : g_bad_wait_max
    $error("mem_ctrl: WAIT_MAX must be >= 1");
  end

  mem_state_e  r_state, w_next;
  mem_op_e     r_op;
  logic [31:0] r_addr, r_wdata, r_mdr;
  logic        r_to, r_illegal;
  logic        w_rw, w_expired, w_timeout, w_acc_rd, w_acc_wr;

  assign w_rw     = (r_state == READ) || (r_state == WRITE);
  assign w_acc_rd = (r_state == IDLE) && req_rd && !req_wr;
  assign w_acc_wr = (r_state == IDLE) && req_wr && !req_rd;

`ifdef MEM_CTRL_TIMEOUT_EN
  mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (!w_rw),
    .i_en      (w_rw && !mem_ready),
    .o_expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  // mem_ready wins when it coincides with the last allowed wait cycle
  assign w_timeout = w_rw && !mem_ready && w_expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:        if (w_acc_rd) w_next = READ;
                   else if (w_acc_wr) w_next = WRITE;
      READ, WRITE: if (mem_ready || w_timeout) w_next = DONE;
      DONE:        w_next = IDLE;
      default:     w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= MEM_OP_RD;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_mdr     <= '0;
      r_to      <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_illegal <= (r_state == IDLE) && req_rd && req_wr;
      r_to      <= w_timeout;
      if (w_acc_rd || w_acc_wr) begin
        r_op    <= w_acc_rd ? MEM_OP_RD : MEM_OP_WR;
        r_addr  <= mar_value;
        r_wdata <= mdr_value;
      end
      if (r_state == READ && mem_ready) r_mdr <= mem_rdata;
    end
  end

  // Outputs decode registered state only; no input reaches an output combinationally
  always_comb begin
    busy      = (r_state != IDLE);
    mem_rd    = (r_state == READ);
    mem_wr    = (r_state == WRITE);
    done      = (r_state == DONE);
    ld_mdr    = (r_state == DONE) && (r_op == MEM_OP_RD) && !r_to;
    err       = ((r_state == DONE) && r_to) || r_illegal;
    mem_addr  = r_addr;
    mem_wdata = r_wdata;
    mdr_in    = r_mdr;
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: stimulus pushes expected responses, a negedge monitor checks them.
module tb_mem_ctrl;

  localparam int unsigned WAIT_MAX = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_rd = 1'b0, req_wr = 1'b0, mem_ready = 1'b0;
  logic [31:0] mar_value = '0, mdr_value = '0, mem_rdata = '0;
  logic        busy, done, err, ld_mdr, mem_rd, mem_wr;
  logic [31:0] mdr_in, mem_addr, mem_wdata;

  mem_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .req_rd(req_rd), .req_wr(req_wr),
    .mar_value(mar_value), .mdr_value(mdr_value), .busy(busy), .done(done),
    .err(err), .ld_mdr(ld_mdr), .mdr_in(mdr_in), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          done, err, ld, rd;
    logic [31:0] mdr, addr, wdata;
    int          strb;
  } resp_t;

  resp_t       exp_q[$];
  int          n_tests = 0, n_fail = 0;
  logic [31:0] model_mdr = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: tracks the strobe run of the current access and checks it when done/err appears
  int          mon_strb = 0;
  bit          mon_rd = 0, mon_unstable = 0;
  logic [31:0] mon_addr = '0, mon_wdata = '0;

  always @(negedge clk) begin
    resp_t e;
    if (!rst_n) begin
      mon_strb = 0;
      mon_unstable = 0;
    end else begin
      if (mem_rd || mem_wr) begin
        if (mon_strb == 0) begin
          mon_addr = mem_addr; mon_wdata = mem_wdata; mon_rd = mem_rd;
        end else if (mem_addr !== mon_addr || mem_wdata !== mon_wdata) begin
          mon_unstable = 1;
        end
        mon_strb++;
      end
      if (done || err) begin
        if (exp_q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("done", 32'(done), 32'(e.done));
          chk("err", 32'(err), 32'(e.err));
          chk("ld_mdr", 32'(ld_mdr), 32'(e.ld));
          chk("mdr_in", mdr_in, e.mdr);
          chk("strobe_cycles", 32'(mon_strb), 32'(e.strb));
          if (e.strb > 0) begin
            chk("strobe_kind_rd", 32'(mon_rd), 32'(e.rd));
            chk("mem_addr", mon_addr, e.addr);
            chk("mem_wdata", mon_wdata, e.wdata);
            chk("addr_data_stable", 32'(mon_unstable), 32'd0);
          end
        end
        mon_strb = 0;
        mon_unstable = 0;
      end
    end
  end

  // One access; waits = strobe cycles before the last one, ready_on = mem_ready on that last cycle
  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] rdata, input int waits, input bit ready_on);
    resp_t e;
    e.done = 1; e.err = !ready_on; e.ld = !wr && ready_on; e.rd = !wr;
    if (e.ld) model_mdr = rdata;
    e.mdr = model_mdr; e.addr = addr; e.wdata = data; e.strb = waits + 1;
    exp_q.push_back(e);
    req_rd = !wr; req_wr = wr; mar_value = addr; mdr_value = data; mem_rdata = rdata;
    @(posedge clk); #1;
    req_rd = 0; req_wr = 0; mar_value = '0; mdr_value = '0;
    mem_ready = (waits == 0) && ready_on;
    for (int k = 1; k <= waits; k++) begin
      @(posedge clk); #1;
      mem_ready = (k == waits) && ready_on;
    end
    @(posedge clk); #1;
    mem_ready = 0; mem_rdata = '0;
    chk("done_latency", 32'(done), 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    resp_t e;
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
    chk("rst_flags", {29'd0, done, err, ld_mdr}, 32'd0);
    chk("rst_mdr_in", mdr_in, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;

    access(1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1'b1);
    access(1'b1, 32'h104, 32'h12345678, 32'h0, 3, 1'b1);
`ifdef MEM_CTRL_TIMEOUT_EN
    access(1'b0, 32'h108, 32'h0, 32'h55AA55AA, WAIT_MAX - 1, 1'b0);
    access(1'b0, 32'h10C, 32'h0, 32'h0BADF00D, WAIT_MAX - 1, 1'b1);
`endif

    // simultaneous requests: lone err pulse, no access
    e.done = 0; e.err = 1; e.ld = 0; e.rd = 0; e.mdr = model_mdr;
    e.addr = '0; e.wdata = '0; e.strb = 0;
    exp_q.push_back(e);
    req_rd = 1; req_wr = 1; mar_value = 32'h500;
    @(posedge clk); #1;
    req_rd = 0; req_wr = 0;
    chk("illegal_err", 32'(err), 32'd1);
    chk("illegal_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("illegal_err_1cyc", 32'(err), 32'd0);
    chk("illegal_busy2", 32'(busy), 32'd0);

    // reset during the second wait cycle of a read
    req_rd = 1; mar_value = 32'h200;
    @(posedge clk); #1;
    req_rd = 0; mem_ready = 0;
    @(posedge clk); #1;
    #2 rst_n = 0;
    #1;
    chk("rstmid_mem_rd", 32'(mem_rd), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_done", 32'(done), 32'd0);
    chk("rstmid_mdr_in", mdr_in, 32'd0);
    model_mdr = '0;
    @(posedge clk); #1; rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_rst_quiet", {30'd0, done, ld_mdr}, 32'd0);
    end
    @(posedge clk); #1;
    access(1'b0, 32'h300, 32'h0, 32'hCAFEF00D, 1, 1'b1);

    // req_wr held: one write every 3 cycles; a read pulse while busy is dropped
    for (int i = 0; i < 3; i++) begin
      e.done = 1; e.err = 0; e.ld = 0; e.rd = 0; e.mdr = model_mdr;
      e.addr = 32'h40; e.wdata = 32'hA5A50001; e.strb = 1;
      exp_q.push_back(e);
    end
    req_wr = 1; mem_ready = 1; mar_value = 32'h40; mdr_value = 32'hA5A50001;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      req_rd = (c == 4);
      if (c == 8) req_wr = 0;
      @(negedge clk);
      chk("b2b_done", 32'(done), 32'((c % 3) == 2));
      chk("b2b_busy", 32'(busy), 32'((c % 3) != 0));
    end
    mem_ready = 0; req_rd = 0;

    repeat (4) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
